// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcodes, instruction field positions, FSM states and flag indices
package proc_pkg;

  localparam logic [4:0] OP_MOVSGPR  = 5'b00000;
  localparam logic [4:0] OP_MOV      = 5'b00001;
  localparam logic [4:0] OP_ADD      = 5'b00010;
  localparam logic [4:0] OP_SUB      = 5'b00011;
  localparam logic [4:0] OP_MUL      = 5'b00100;
  localparam logic [4:0] OP_OR       = 5'b00101;
  localparam logic [4:0] OP_AND      = 5'b00110;
  localparam logic [4:0] OP_XOR      = 5'b00111;
  localparam logic [4:0] OP_XNOR     = 5'b01000;
  localparam logic [4:0] OP_NAND     = 5'b01001;
  localparam logic [4:0] OP_NOR      = 5'b01010;
  localparam logic [4:0] OP_NOT      = 5'b01011;
  localparam logic [4:0] OP_STOREREG = 5'b01101;
  localparam logic [4:0] OP_STOREDIN = 5'b01110;
  localparam logic [4:0] OP_SENDDOUT = 5'b01111;
  localparam logic [4:0] OP_SENDREG  = 5'b10001;
  localparam logic [4:0] OP_JMP      = 5'b10010;
  localparam logic [4:0] OP_JC       = 5'b10011;
  localparam logic [4:0] OP_JS       = 5'b10100;
  localparam logic [4:0] OP_JZ       = 5'b10101;
  localparam logic [4:0] OP_JV       = 5'b10110;
  localparam logic [4:0] OP_HALT     = 5'b11011;

  localparam int IR_OP_HI    = 31;
  localparam int IR_OP_LO    = 27;
  localparam int IR_RDST_HI  = 26;
  localparam int IR_RDST_LO  = 22;
  localparam int IR_RSRC1_HI = 21;
  localparam int IR_RSRC1_LO = 17;
  localparam int IR_IMM      = 16;
  localparam int IR_RSRC2_HI = 15;
  localparam int IR_RSRC2_LO = 11;
  localparam int IR_ISRC_HI  = 15;
  localparam int IR_ISRC_LO  = 0;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_EXEC, ST_WAIT, ST_NEXT, ST_HALT
  } state_t;

  // Only the arithmetic/logic group (add..not) updates the flag register.
  function automatic logic sets_flags(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/proc_core_fsm_if.sv
// rtl/proc_core_fsm_if.sv - control, program-load and data bus bundle of the core
interface proc_core_fsm_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 4
);
  logic              start;
  logic              imem_we;
  logic [PC_W-1:0]   imem_waddr;
  logic [31:0]       imem_wdata;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              halted;
  logic [PC_W-1:0]   pc;
  logic [3:0]        flags;

  modport master (
    output start, imem_we, imem_waddr, imem_wdata, din,
    input  dout, dout_valid, halted, pc, flags
  );

  modport slave (
    input  start, imem_we, imem_waddr, imem_wdata, din,
    output dout, dout_valid, halted, pc, flags
  );
endinterface

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational ALU: result, multiply high half and flags
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] hi,
  output logic [3:0]        flags
);
  localparam int M = DATA_W - 1;

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    result = '0;
    hi     = '0;
    flags  = '0;
    sum    = '0;
    prod   = '0;
    case (op)
      OP_ADD: begin
        sum           = {1'b0, a} + {1'b0, b};
        result        = sum[DATA_W-1:0];
        flags[FLAG_C] = sum[DATA_W];
        flags[FLAG_V] = (a[M] == b[M]) && (result[M] != a[M]);
      end
      OP_SUB: begin
        // Bit DATA_W of the widened difference is the borrow.
        sum           = {1'b0, a} - {1'b0, b};
        result        = sum[DATA_W-1:0];
        flags[FLAG_C] = sum[DATA_W];
        flags[FLAG_V] = (a[M] != b[M]) && (result[M] != a[M]);
      end
      OP_MUL: begin
        prod   = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        result = prod[DATA_W-1:0];
        hi     = prod[2*DATA_W-1:DATA_W];
      end
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_NOT:  result = ~a;
      default: ;
    endcase
    flags[FLAG_S] = (op == OP_MUL) ? hi[M] : result[M];
    flags[FLAG_Z] = (op == OP_MUL) ? (prod == '0) : (result == '0);
  end
endmodule

// File: rtl/proc_core_fsm.sv
// rtl/proc_core_fsm.sv - multi-cycle fetch/execute/next processor core
module proc_core_fsm
  import proc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_GPR    = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  parameter int EXEC_DELAY = 2
) (
  input  logic           clk,
  input  logic           sys_rst,
  proc_core_fsm_if.slave bus
);
  localparam int PC_W   = $clog2(IMEM_DEPTH);
  localparam int DA_W   = $clog2(DMEM_DEPTH);
  localparam int WCNT_W = (EXEC_DELAY > 1) ? $clog2(EXEC_DELAY) : 1;

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc_q;
  logic [31:0]         ir;
  logic [DATA_W-1:0]   sgpr, dout_q;
  logic                dout_valid_q;
  logic [3:0]          flags_q;
  logic [WCNT_W-1:0]   wcnt;

  logic [31:0]         imem [IMEM_DEPTH];
  logic [DATA_W-1:0]   gpr  [NUM_GPR];
  logic [DATA_W-1:0]   dmem [DMEM_DEPTH];

  logic [4:0]          op, rdst, rsrc1, rsrc2;
  logic                imm_mode;
  logic [15:0]         isrc;
  logic [DA_W-1:0]     daddr;
  logic [DATA_W-1:0]   imm_ext, src_a, src_b, alu_res, alu_hi, gpr_wdata;
  logic [3:0]          alu_flags;
  logic                gpr_we, taken, imem_wr_ok;
  logic [PC_W-1:0]     pc_inc;

  assign op       = ir[IR_OP_HI:IR_OP_LO];
  assign rdst     = ir[IR_RDST_HI:IR_RDST_LO];
  assign rsrc1    = ir[IR_RSRC1_HI:IR_RSRC1_LO];
  assign imm_mode = ir[IR_IMM];
  assign rsrc2    = ir[IR_RSRC2_HI:IR_RSRC2_LO];
  assign isrc     = ir[IR_ISRC_HI:IR_ISRC_LO];
  assign daddr    = isrc[DA_W-1:0];
  assign imm_ext  = DATA_W'(isrc);

  // Registers beyond NUM_GPR read as zero.
  function automatic logic [DATA_W-1:0] rd_gpr(input logic [4:0] idx);
    return (int'(idx) < NUM_GPR) ? gpr[idx] : '0;
  endfunction

  assign src_a = (op == OP_NOT && imm_mode) ? imm_ext : rd_gpr(rsrc1);
  assign src_b = imm_mode ? imm_ext : rd_gpr(rsrc2);

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (src_a),
    .b      (src_b),
    .result (alu_res),
    .hi     (alu_hi),
    .flags  (alu_flags)
  );

  always_comb begin
    gpr_we    = 1'b0;
    gpr_wdata = alu_res;
    if (op == OP_MOVSGPR) begin
      gpr_we    = 1'b1;
      gpr_wdata = sgpr;
    end else if (op == OP_MOV) begin
      gpr_we    = 1'b1;
      gpr_wdata = imm_mode ? imm_ext : rd_gpr(rsrc1);
    end else if (op == OP_SENDREG) begin
      gpr_we    = 1'b1;
      gpr_wdata = dmem[daddr];
    end else if (sets_flags(op)) begin
      gpr_we    = 1'b1;
    end
  end

  always_comb begin
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = flags_q[FLAG_C];
      OP_JS:   taken = flags_q[FLAG_S];
      OP_JZ:   taken = flags_q[FLAG_Z];
      OP_JV:   taken = flags_q[FLAG_V];
      default: taken = 1'b0;
    endcase
  end

  assign pc_inc     = (pc_q == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
  assign imem_wr_ok = bus.imem_we && (state == ST_IDLE || state == ST_HALT);

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALT: if (bus.start) state_nxt = ST_FETCH;
      ST_FETCH:         state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_HALT)        state_nxt = ST_HALT;
        else if (EXEC_DELAY == 0) state_nxt = ST_NEXT;
        else                      state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (wcnt == WCNT_W'(EXEC_DELAY - 1)) state_nxt = ST_NEXT;
      ST_NEXT:  state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Storage arrays carry no reset; they are only written from EXEC or while stopped.
  always_ff @(posedge clk) begin
    if (state == ST_EXEC) begin
      if (gpr_we && int'(rdst) < NUM_GPR) gpr[rdst] <= gpr_wdata;
      if (op == OP_STOREREG) dmem[daddr] <= rd_gpr(rsrc1);
      if (op == OP_STOREDIN) dmem[daddr] <= bus.din;
    end
    if (imem_wr_ok) imem[bus.imem_waddr] <= bus.imem_wdata;
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pc_q         <= '0;
      ir           <= '0;
      sgpr         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      flags_q      <= '0;
      wcnt         <= '0;
    end else begin
      dout_valid_q <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: if (bus.start) pc_q <= '0;
        ST_FETCH: ir <= imem[pc_q];
        ST_EXEC: begin
          if (sets_flags(op)) flags_q <= alu_flags;
          if (op == OP_MUL) sgpr <= alu_hi;
          if (op == OP_SENDDOUT) begin
            dout_q       <= dmem[daddr];
            dout_valid_q <= 1'b1;
          end
          wcnt <= '0;
        end
        ST_WAIT: wcnt <= wcnt + 1'b1;
        ST_NEXT: pc_q <= taken ? isrc[PC_W-1:0] : pc_inc;
        default: ;
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.halted     = (state == ST_HALT);
  assign bus.pc         = pc_q;
  assign bus.flags      = flags_q;
endmodule

// File: tb/tb_proc_core_fsm.sv
// tb/tb_proc_core_fsm.sv - scoreboard bench for proc_core_fsm
module tb_proc_core_fsm;
  localparam logic [4:0] MOVSGPR = 5'h00, MOV = 5'h01, ADD = 5'h02, SUB = 5'h03, MUL = 5'h04;
  localparam logic [4:0] ORR = 5'h05, STOREREG = 5'h0D, SENDDOUT = 5'h0F;
  localparam logic [4:0] JMP = 5'h12, JZ = 5'h15, HALT = 5'h1B;

  logic clk = 1'b0;
  logic sys_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  pc_trace[$];

  proc_core_fsm_if #(.DATA_W(16), .PC_W(4)) bus ();

  proc_core_fsm dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sys_rst && bus.dout_valid) begin
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected got=%h", bus.dout);
      end else begin
        e = exp_q.pop_front();
        if (bus.dout !== e) begin
          errors++;
          $display("FAIL dout got=%h want=%h", bus.dout, e);
        end
      end
    end
  end

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] src);
    return {op, rd, rs1, 1'b1, src};
  endfunction

  task automatic load(input logic [3:0] a, input logic [31:0] w);
    @(negedge clk);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = a;
    bus.imem_wdata = w;
    @(negedge clk);
    bus.imem_we    = 1'b0;
  endtask

  task automatic start_prog();
    pc_trace.delete();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pc_trace.push_back(bus.pc);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!bus.halted && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.pc != pc_trace[$]) pc_trace.push_back(bus.pc);
    end
    checks++;
    if (bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL run_timeout halted=%b want=1", bus.halted);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_dout=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_trace(input string name, input logic [3:0] want[$]);
    bit ok = (pc_trace.size() == want.size());
    for (int i = 0; ok && i < want.size(); i++) if (pc_trace[i] !== want[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s trace_len=%0d want_len=%0d", name, pc_trace.size(), want.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_val("rst_pc", 16'(bus.pc), 16'h0);
    check_val("rst_halted", 16'(bus.halted), 16'h0);
    check_val("rst_dout", bus.dout, 16'h0);
    check_val("rst_dout_valid", 16'(bus.dout_valid), 16'h0);
    check_val("rst_flags", 16'(bus.flags), 16'h0);
    sys_rst = 1'b1;
  endtask

  task automatic test_basic();
    load(0, enc(MOV, 1, 0, 16'd5));
    load(1, enc(ADD, 2, 1, 16'd3));
    load(2, enc(STOREREG, 0, 2, 16'd0));
    load(3, enc(SENDDOUT, 0, 0, 16'd0));
    load(4, enc(HALT, 0, 0, 16'd0));
    exp_q.push_back(16'd8);
    start_prog();
    wait_halt(200);
    check_drained("basic_dout");
    check_val("basic_flags", 16'(bus.flags), 16'h0);
    check_val("basic_halt_pc", 16'(bus.pc), 16'd4);
  endtask

  task automatic test_flags();
    logic [15:0] a_v[3]   = '{16'hFFFF, 16'h7FFF, 16'h0000};
    logic [4:0]  op_v[3]  = '{ADD, ADD, SUB};
    logic [3:0]  want[3]  = '{4'b0101, 4'b1010, 4'b1001};
    for (int i = 0; i < 3; i++) begin
      load(0, enc(MOV, 1, 0, a_v[i]));
      load(1, enc(op_v[i], 2, 1, 16'd1));
      load(2, enc(HALT, 0, 0, 16'd0));
      start_prog();
      wait_halt(100);
      check_val($sformatf("flags_case%0d", i), 16'(bus.flags), 16'(want[i]));
    end
  endtask

  task automatic test_wrap();
    load(0, enc(JZ, 0, 0, 16'd4));
    load(1, enc(MOV, 1, 0, 16'd0));
    load(2, enc(JMP, 0, 0, 16'd15));
    load(4, enc(STOREREG, 0, 2, 16'd4));
    load(5, enc(SENDDOUT, 0, 0, 16'd4));
    load(6, enc(HALT, 0, 0, 16'd0));
    load(15, enc(ORR, 2, 1, 16'd0));
    exp_q.push_back(16'd0);
    start_prog();
    wait_halt(200);
    check_trace("wrap_pc_trace", '{4'd0, 4'd1, 4'd2, 4'd15, 4'd0, 4'd4, 4'd5, 4'd6});
    check_drained("wrap_dout");
  endtask

  task automatic test_mul();
    load(0, enc(MOV, 1, 0, 16'h1234));
    load(1, enc(MUL, 2, 1, 16'h0100));
    load(2, enc(MOVSGPR, 3, 0, 16'd0));
    load(3, enc(STOREREG, 0, 2, 16'd1));
    load(4, enc(STOREREG, 0, 3, 16'd2));
    load(5, enc(SENDDOUT, 0, 0, 16'd1));
    load(6, enc(SENDDOUT, 0, 0, 16'd2));
    load(7, enc(HALT, 0, 0, 16'd0));
    exp_q.push_back(16'h3400);
    exp_q.push_back(16'h0012);
    start_prog();
    wait_halt(200);
    check_drained("mul_dout");
    check_val("mul_flags", 16'(bus.flags), 16'h0);
  endtask

  task automatic test_loop();
    load(0, enc(MOV, 1, 0, 16'd3));
    load(1, enc(SUB, 1, 1, 16'd1));
    load(2, enc(JZ, 0, 0, 16'd4));
    load(3, enc(JMP, 0, 0, 16'd1));
    load(4, enc(STOREREG, 0, 1, 16'd3));
    load(5, enc(SENDDOUT, 0, 0, 16'd3));
    load(6, enc(HALT, 0, 0, 16'd0));
    exp_q.push_back(16'd0);
    start_prog();
    wait_halt(300);
    check_trace("loop_pc_trace",
                '{4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6});
    check_val("loop_flags", 16'(bus.flags), 16'b0100);
    check_drained("loop_dout");
  endtask

  task automatic test_imem_we_running();
    load(0, enc(MOV, 1, 0, 16'h00AA));
    load(1, enc(STOREREG, 0, 1, 16'd5));
    load(2, enc(SENDDOUT, 0, 0, 16'd5));
    load(3, enc(HALT, 0, 0, 16'd0));
    exp_q.push_back(16'h00AA);
    start_prog();
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 4'd2;
    bus.imem_wdata = enc(HALT, 0, 0, 16'd0);
    repeat (3) @(negedge clk);
    bus.imem_we    = 1'b0;
    wait_halt(200);
    check_drained("we_running_dout");
  endtask

  task automatic test_start_with_write();
    pc_trace.delete();
    @(negedge clk);
    bus.start      = 1'b1;
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 4'd0;
    bus.imem_wdata = enc(MOV, 1, 0, 16'h00BB);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.imem_we    = 1'b0;
    pc_trace.push_back(bus.pc);
    exp_q.push_back(16'h00BB);
    wait_halt(200);
    check_drained("start_write_dout");
  endtask

  task automatic test_reset_in_wait();
    load(0, enc(MOV, 1, 0, 16'h0077));
    load(1, enc(STOREREG, 0, 1, 16'd6));
    load(2, enc(SENDDOUT, 0, 0, 16'd6));
    load(3, enc(HALT, 0, 0, 16'd0));
    check_val("pre_rst_dout", bus.dout, 16'h00BB);
    check_val("pre_rst_flags", 16'(bus.flags), 16'b0100);
    start_prog();
    repeat (7) @(negedge clk);
    check_val("pre_rst_pc", 16'(bus.pc), 16'd1);
    sys_rst = 1'b0;
    #1;
    check_val("midrst_pc", 16'(bus.pc), 16'h0);
    check_val("midrst_dout", bus.dout, 16'h0);
    check_val("midrst_flags", 16'(bus.flags), 16'h0);
    check_val("midrst_halted", 16'(bus.halted), 16'h0);
    @(negedge clk);
    sys_rst = 1'b1;
    exp_q.push_back(16'h0077);
    start_prog();
    check_val("rerun_start_pc", 16'(pc_trace[0]), 16'h0);
    wait_halt(200);
    check_drained("rerun_dout");
    check_val("rerun_halt_pc", 16'(bus.pc), 16'd3);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    bus.din        = '0;
    test_reset();
    test_basic();
    test_flags();
    test_wrap();
    test_mul();
    test_loop();
    test_imem_we_running();
    test_start_with_write();
    test_reset_in_wait();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
